// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared divider state encodings, widths and constants
package seq_divider_pkg;
  localparam int DEF_N_W = 8;
  localparam int DEF_D_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  localparam logic [DEF_N_W-1:0] DBZ_QUOT = '1;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/ready/done handshake and operand/result bus of the divider
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int N_W = DEF_N_W,
  parameter int D_W = DEF_D_W
);
  logic           start;
  logic [N_W-1:0] dividend;
  logic [D_W-1:0] divisor;
  logic           ready;
  logic           done;
  logic [N_W-1:0] quotient;
  logic [D_W-1:0] remainder;
  logic           div_by_zero;
  modport master(output start, dividend, divisor, input ready, done, quotient, remainder, div_by_zero);
  modport slave(input start, dividend, divisor, output ready, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one combinational restoring-division step
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int D_W = DEF_D_W
) (
  input  logic [D_W:0]   p,
  input  logic           n_bit,
  input  logic [D_W-1:0] divisor,
  output logic [D_W:0]   p_nxt,
  output logic           q_bit
);
  logic [D_W:0] t;
  // shift the next dividend bit into the partial remainder and subtract when it fits
  always_comb begin
    t     = {p[D_W-1:0], n_bit};
    q_bit = t >= {1'b0, divisor};
    p_nxt = q_bit ? t - {1'b0, divisor} : t;
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N_W = DEF_N_W,
  parameter int D_W = DEF_D_W
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(N_W);
  localparam logic [CW-1:0] LAST = CW'(N_W - 1);
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [D_W:0]   p_q, p_d, p_nxt;
  logic [N_W-1:0] qsr_q, qsr_d;
  logic [D_W-1:0] dsr_q, dsr_d;
  logic [N_W-1:0] quot_q, quot_d;
  logic [D_W-1:0] rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           q_bit;

  seq_divider_div_step #(.D_W(D_W)) u_step (
    .p      (p_q),
    .n_bit  (qsr_q[N_W-1]),
    .divisor(dsr_q),
    .p_nxt  (p_nxt),
    .q_bit  (q_bit)
  );

  // FSM next state, datapath step and result load; results only change on a DONE entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    qsr_d   = qsr_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.divisor != '0) begin
          qsr_d   = bus.dividend;
          dsr_d   = bus.divisor;
          p_d     = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          quot_d  = '1;
          rem_d   = '0;
          dbz_d   = 1'b1;
          state_d = DONE;
        end
      end
      BUSY: begin
        qsr_d = {qsr_q[N_W-2:0], q_bit};
        p_d   = p_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quot_d  = qsr_d;
          rem_d   = p_nxt[D_W-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      qsr_q   <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      qsr_q   <= qsr_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.ready       = state_q == IDLE;
  assign bus.done        = state_q == DONE;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule
